// File: rtl/pcma_pkg.sv
// Shared definitions for the PCMA coefficient loader: default geometry and
// the load-sequencer state encoding.
package pcma_pkg;

  localparam int DEF_COE_WIDTH     = 16;
  localparam int DEF_INV_COE_WIDTH = 8;
  localparam int FULL_COE_WIDTH    = DEF_COE_WIDTH + DEF_INV_COE_WIDTH;
  localparam int DEF_EQ_LEN        = 19;
  localparam int DEF_ADDR_W        = 5;
  localparam int DEF_LOAD_GAP      = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESET,
    ST_PGAP,
    ST_LOAD,
    ST_WAIT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/pcma_coe_bank.sv
// Host-writable coefficient register file with range-checked write port and a
// registered read port that forwards a same-cycle write.
module pcma_coe_bank #(
  parameter int WIDTH  = pcma_pkg::FULL_COE_WIDTH,
  parameter int DEPTH  = pcma_pkg::DEF_EQ_LEN,
  parameter int ADDR_W = pcma_pkg::DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en_i,
  input  logic              wr_allow_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  output logic              wr_err_o,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0]  rd_data_o
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;
  logic             wr_err_q;
  logic             wr_ok;

  assign wr_ok = wr_en_i && wr_allow_i && ({1'b0, wr_addr_i} < DEPTH_W);

  // NOTE: the bank is flops, not a RAM macro, so it can and must be cleared
  // by reset; a true RAM would need an explicit clearing walk instead.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_data_q <= '0;
      wr_err_q  <= 1'b0;
    end else begin
      wr_err_q <= wr_en_i & ~wr_ok;
      if (wr_ok) mem_q[wr_addr_i] <= wr_data_i;
      // A write landing in the same cycle as the read wins, so start+write
      // streams the freshly written value.
      if (rd_en_i) rd_data_q <= (wr_ok && (wr_addr_i == rd_addr_i)) ? wr_data_i
                                                                   : mem_q[rd_addr_i];
    end
  end

  assign wr_err_o  = wr_err_q;
  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/pcma_coe_loader.sv
// Coefficient load sequencer for the PCMA equalizer: optional preset strobe,
// then EQ_LEN spaced load strobes, with teach enable gated while busy.
module pcma_coe_loader import pcma_pkg::*; #(
  parameter int COE_WIDTH     = DEF_COE_WIDTH,
  parameter int INV_COE_WIDTH = DEF_INV_COE_WIDTH,
  parameter int EQ_LEN        = DEF_EQ_LEN,
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int LOAD_GAP      = DEF_LOAD_GAP
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               cfg_wr_en,
  input  logic [ADDR_W-1:0]                  cfg_wr_addr,
  input  logic [COE_WIDTH+INV_COE_WIDTH-1:0] cfg_wr_data,
  output logic                               cfg_wr_err,
  input  logic                               start,
  input  logic                               use_preset,
  input  logic                               teach_req,
  output logic                               busy,
  output logic                               done,
  output logic                               o_preset_coe,
  output logic                               o_load_coe,
  output logic [COE_WIDTH+INV_COE_WIDTH-1:0] o_init_coe,
  output logic                               o_teach_en
);

  localparam int              FULL_W   = COE_WIDTH + INV_COE_WIDTH;
  localparam int              GAP_W    = (LOAD_GAP > 1) ? $clog2(LOAD_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((LOAD_GAP > 0) ? LOAD_GAP - 1 : 0);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(EQ_LEN - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              busy_q, done_q, preset_q, load_q, teach_q;

  // NOTE: every always_comb output gets a default first so no path can hold
  // a stale value and infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d   = '0;
          state_d = use_preset ? ST_PRESET : ST_LOAD;
        end
      end
      ST_PRESET: state_d = ST_PGAP;
      ST_PGAP:   state_d = ST_LOAD;
      ST_LOAD: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          gap_d   = '0;
          state_d = (LOAD_GAP > 0) ? ST_WAIT : ST_LOAD;
        end
      end
      ST_WAIT: begin
        if (gap_q == GAP_LAST) state_d = ST_LOAD;
        else                   gap_d   = gap_q + GAP_W'(1);
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from next state so strobes line up with the
  // state they belong to and with the bank's registered read data.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      gap_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      preset_q <= 1'b0;
      load_q   <= 1'b0;
      teach_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      gap_q    <= gap_d;
      busy_q   <= (state_d != ST_IDLE);
      done_q   <= (state_d == ST_DONE);
      preset_q <= (state_d == ST_PRESET);
      load_q   <= (state_d == ST_LOAD);
      teach_q  <= teach_req & (state_d == ST_IDLE);
    end
  end

  pcma_coe_bank #(
    .WIDTH  (FULL_W),
    .DEPTH  (EQ_LEN),
    .ADDR_W (ADDR_W)
  ) u_bank (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en_i    (cfg_wr_en),
    .wr_allow_i (state_q == ST_IDLE),
    .wr_addr_i  (cfg_wr_addr),
    .wr_data_i  (cfg_wr_data),
    .wr_err_o   (cfg_wr_err),
    .rd_en_i    (state_d == ST_LOAD),
    .rd_addr_i  (idx_d),
    .rd_data_o  (o_init_coe)
  );

  assign busy         = busy_q;
  assign done         = done_q;
  assign o_preset_coe = preset_q;
  assign o_load_coe   = load_q;
  assign o_teach_en   = teach_q;

endmodule

// File: tb/tb_pcma_coe_loader.sv
// Scoreboard bench for pcma_coe_loader: expected load data is queued at start
// and popped against each load strobe, alongside timing and gating checks.
module tb_pcma_coe_loader;

  localparam int CW  = 16;
  localparam int IW  = 8;
  localparam int FW  = CW + IW;
  localparam int EQ  = 19;
  localparam int AW  = 5;
  localparam int GAP = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cfg_wr_en;
  logic [AW-1:0] cfg_wr_addr;
  logic [FW-1:0] cfg_wr_data;
  logic          cfg_wr_err;
  logic          start;
  logic          use_preset;
  logic          teach_req;
  logic          busy;
  logic          done;
  logic          o_preset_coe;
  logic          o_load_coe;
  logic [FW-1:0] o_init_coe;
  logic          o_teach_en;

  always #5 clk = ~clk;

  pcma_coe_loader #(
    .COE_WIDTH     (CW),
    .INV_COE_WIDTH (IW),
    .EQ_LEN        (EQ),
    .ADDR_W        (AW),
    .LOAD_GAP      (GAP)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cfg_wr_en    (cfg_wr_en),
    .cfg_wr_addr  (cfg_wr_addr),
    .cfg_wr_data  (cfg_wr_data),
    .cfg_wr_err   (cfg_wr_err),
    .start        (start),
    .use_preset   (use_preset),
    .teach_req    (teach_req),
    .busy         (busy),
    .done         (done),
    .o_preset_coe (o_preset_coe),
    .o_load_coe   (o_load_coe),
    .o_init_coe   (o_init_coe),
    .o_teach_en   (o_teach_en)
  );

  int            total = 0;
  int            bad   = 0;
  logic [FW-1:0] model_bank [EQ];
  logic [FW-1:0] exp_q [$];
  logic [FW-1:0] hold_val;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < EQ; k++) model_bank[k] = '0;
    exp_q.delete();
    hold_val = '0;
  endtask

  // Called at a falling edge while idle; returns at a falling edge.
  task automatic do_write(input int addr, input logic [FW-1:0] data);
    bit ok;
    ok          = (addr < EQ);
    cfg_wr_en   = 1'b1;
    cfg_wr_addr = AW'(addr);
    cfg_wr_data = data;
    @(negedge clk);
    cfg_wr_en = 1'b0;
    check("wr_err", 32'(cfg_wr_err), 32'(!ok));
    if (ok) model_bank[addr] = data;
  endtask

  task automatic run_seq(input bit preset, input int abort_after, input bit wr_with_start,
                         input int ws_addr, input logic [FW-1:0] ws_data, input bit busy_poke);
    int c, n_strobe, last_c, first_exp, stray;
    bit finished;
    check("idle_teach", 32'(o_teach_en), 32'(teach_req));
    check("idle_busy", 32'(busy), 32'd0);
    start      = 1'b1;
    use_preset = preset;
    if (wr_with_start) begin
      cfg_wr_en   = 1'b1;
      cfg_wr_addr = AW'(ws_addr);
      cfg_wr_data = ws_data;
      model_bank[ws_addr] = ws_data;
    end
    exp_q.delete();
    for (int k = 0; k < EQ; k++) exp_q.push_back(model_bank[k]);
    c = 0; n_strobe = 0; last_c = 0; finished = 0;
    first_exp = preset ? 3 : 1;
    while (!finished && c < 300) begin
      @(negedge clk);
      c++;
      if (c == 1) begin
        start = 1'b0; use_preset = 1'b0; cfg_wr_en = 1'b0;
        check("busy_rise", 32'(busy), 32'd1);
        check("teach_drop", 32'(o_teach_en), 32'd0);
        check("preset_first", 32'(o_preset_coe), 32'(preset));
        if (wr_with_start) check("wr_err_start", 32'(cfg_wr_err), 32'd0);
      end
      if (c == 2 && preset) check("preset_one_cycle", 32'(o_preset_coe), 32'd0);
      if (busy_poke && c == 4) begin
        start = 1'b1; cfg_wr_en = 1'b1; cfg_wr_addr = AW'(3); cfg_wr_data = 24'hBADBAD;
      end
      if (busy_poke && c == 5) begin
        check("wr_err_busy", 32'(cfg_wr_err), 32'd1);
        start = 1'b0; cfg_wr_en = 1'b0;
      end
      check("no_overlap", 32'(o_preset_coe & o_load_coe), 32'd0);
      if (o_load_coe) begin
        n_strobe++;
        if (exp_q.size() == 0) check("strobe_count_over", 32'(n_strobe), 32'(EQ));
        else begin
          hold_val = exp_q.pop_front();
          check("load_data", 32'(o_init_coe), 32'(hold_val));
        end
        if (n_strobe == 1) check("first_strobe_cycle", 32'(c), 32'(first_exp));
        else               check("strobe_spacing", 32'(c - last_c), 32'(GAP + 1));
        last_c = c;
        if (abort_after > 0 && n_strobe == abort_after) begin
          reset_n = 1'b0;
          #1;
          check("abort_load", 32'(o_load_coe), 32'd0);
          check("abort_busy", 32'(busy), 32'd0);
          check("abort_init", 32'(o_init_coe), 32'd0);
          check("abort_teach", 32'(o_teach_en), 32'd0);
          clear_model();
          stray = 0;
          repeat (8) begin
            @(negedge clk);
            stray += int'(o_load_coe) + int'(done) + int'(o_preset_coe) + int'(busy);
          end
          check("abort_quiet", 32'(stray), 32'd0);
          reset_n = 1'b1;
          @(negedge clk);
          finished = 1;
        end
      end else begin
        check("init_hold", 32'(o_init_coe), 32'(hold_val));
        if (done) begin
          check("done_after_last", 32'(c - last_c), 32'd1);
          check("strobe_count", 32'(n_strobe), 32'(EQ));
          check("done_busy", 32'(busy), 32'd1);
          @(negedge clk);
          check("post_busy", 32'(busy), 32'd0);
          check("post_done", 32'(done), 32'd0);
          check("teach_back", 32'(o_teach_en), 32'd1);
          stray = 0;
          repeat (6) begin
            @(negedge clk);
            stray += int'(o_load_coe) + int'(done) + int'(o_preset_coe);
          end
          check("no_restart", 32'(stray), 32'd0);
          finished = 1;
        end
      end
    end
    if (!finished) check("seq_timeout", 32'(c), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
    start = 1'b0; use_preset = 1'b0; teach_req = 1'b1;
    clear_model();
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_preset", 32'(o_preset_coe), 32'd0);
    check("rst_load", 32'(o_load_coe), 32'd0);
    check("rst_init", 32'(o_init_coe), 32'd0);
    check("rst_teach", 32'(o_teach_en), 32'd0);
    check("rst_wr_err", 32'(cfg_wr_err), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // Freshly reset bank streams zeros.
    run_seq(1'b0, 0, 1'b0, 0, '0, 1'b0);

    for (int k = 0; k < EQ; k++) do_write(k, FW'(32'h010000 + k));
    run_seq(1'b0, 0, 1'b0, 0, '0, 1'b0);
    run_seq(1'b1, 0, 1'b0, 0, '0, 1'b0);

    // Out-of-range write, then a write and restart attempt while busy.
    do_write(19, 24'h123456);
    do_write(31, 24'h654321);
    run_seq(1'b0, 0, 1'b0, 0, '0, 1'b1);

    // Write in the same cycle as start must be streamed.
    run_seq(1'b0, 0, 1'b1, 7, 24'hABCDEF, 1'b0);
    run_seq(1'b1, 0, 1'b1, 0, 24'h5A5A5A, 1'b0);

    // Reset after the 5th strobe, then the cleared bank streams zeros.
    run_seq(1'b0, 5, 1'b0, 0, '0, 1'b0);
    @(negedge clk);
    run_seq(1'b0, 0, 1'b0, 0, '0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
